// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding ROM read (req/ack) feeding a one-entry
// instruction buffer towards decode (valid/ready), with flush support for taken jumps.
module instruction_fetch #(
    parameter int unsigned ADDR_SIZE = 16,
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [ADDR_SIZE-1:0] pc_addr,
    output logic                 pc_inc,
    output logic                 rom_req,
    output logic [ADDR_SIZE-1:0] rom_addr,
    input  logic                 rom_ack,
    input  logic [DATA_SIZE-1:0] rom_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [DATA_SIZE-1:0] instr,
    output logic [ADDR_SIZE-1:0] instr_addr,
    input  logic                 flush
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StWait
    } state_e;

    state_e                 state_q, state_d;
    logic                   pc_inc_q, pc_inc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [DATA_SIZE-1:0]   instr_q, instr_d;
    logic [ADDR_SIZE-1:0]   instr_addr_q, instr_addr_d;
    logic                   discard_q, discard_d;

    always_comb begin
        state_d       = state_q;
        pc_inc_d      = 1'b0;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        discard_d     = discard_q;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (rom_ack) begin
                    if (flush || discard_q) begin
                        // Data belongs to a fetch made before the jump; drop it.
                        discard_d = 1'b0;
                        state_d   = run ? StReq : StIdle;
                    end else begin
                        instr_d       = rom_data;
                        instr_addr_d  = pc_addr;
                        instr_valid_d = 1'b1;
                        pc_inc_d      = 1'b1;
                        state_d       = StHold;
                    end
                end else if (flush) begin
                    // The request cannot be withdrawn, so remember to drop its data.
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    state_d       = run ? StReq : StIdle;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = StWait;
                end
            end
            StWait: begin
                // Bubble so the PC update from pc_inc or a decode load is visible.
                state_d = run ? StReq : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            pc_inc_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_inc_q      <= pc_inc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            discard_q     <= discard_d;
        end
    end

    assign rom_req     = (state_q == StReq);
    assign rom_addr    = rom_req ? pc_addr : '0;
    assign pc_inc      = pc_inc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run checked against a
// transaction-level model (captured-instruction queue and request-level rules).
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        run = 1'b0;
    logic [15:0] pc_addr;
    logic        pc_inc;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack = 1'b0;
    logic [15:0] rom_data = 16'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        flush = 1'b0;

    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    instruction_fetch #(
        .ADDR_SIZE(16),
        .DATA_SIZE(16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .pc_addr    (pc_addr),
        .pc_inc     (pc_inc),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_addr (instr_addr),
        .flush      (flush)
    );

    always #5 clock = ~clock;

    // Program counter model: a jump load wins over an increment.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc_addr <= 16'h0;
        else if (pc_load) pc_addr <= pc_load_val;
        else if (pc_inc) pc_addr <= pc_addr + 16'd1;
    end

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ a ^ 16'hEC10;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        #2;
        reset_n = 1'b0;
        run = 1'b0; flush = 1'b0; instr_ready = 1'b0; rom_ack = 1'b0; pc_load = 1'b0;
        #1;
        n_cmp++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", rom_req); end
        n_cmp++; if (pc_inc !== 1'b0) begin n_fail++; $display("FAIL rst_inc: got %b want 0", pc_inc); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 16'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0000", instr); end
        n_cmp++; if (instr_addr !== 16'h0) begin n_fail++; $display("FAIL rst_iaddr: got %h want 0000", instr_addr); end
        n_cmp++; if (rom_addr !== 16'h0) begin n_fail++; $display("FAIL rst_raddr: got %h want 0000", rom_addr); end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        run = 1'b1; instr_ready = 1'b1;
        tick();
        n_cmp++; if (rom_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b want 1", rom_req); end
        n_cmp++; if (rom_addr !== 16'h0000) begin n_fail++; $display("FAIL basic_raddr0: got %h want 0000", rom_addr); end
        rom_ack = 1'b1; rom_data = rom_word(16'h0000);
        tick();
        n_cmp++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_1cyc: got %b want 0", rom_req); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", instr_valid); end
        n_cmp++; if (instr !== 16'hEC10) begin n_fail++; $display("FAIL basic_instr: got %h want ec10", instr); end
        n_cmp++; if (instr_addr !== 16'h0000) begin n_fail++; $display("FAIL basic_iaddr: got %h want 0000", instr_addr); end
        n_cmp++; if (pc_inc !== 1'b1) begin n_fail++; $display("FAIL basic_inc: got %b want 1", pc_inc); end
        rom_ack = 1'b0; rom_data = 16'h0;
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_off: got %b want 0", instr_valid); end
        n_cmp++; if (pc_inc !== 1'b0) begin n_fail++; $display("FAIL basic_inc_pulse: got %b want 0", pc_inc); end
        n_cmp++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req: got %b want 0", rom_req); end
        n_cmp++; if (instr !== 16'hEC10) begin n_fail++; $display("FAIL basic_instr_hold: got %h want ec10", instr); end
        tick();
        n_cmp++; if (rom_req !== 1'b1) begin n_fail++; $display("FAIL basic_req2: got %b want 1", rom_req); end
        n_cmp++; if (rom_addr !== 16'h0001) begin n_fail++; $display("FAIL basic_raddr1: got %h want 0001", rom_addr); end
        run = 1'b0; rom_ack = 1'b1; rom_data = rom_word(16'h0001);
        tick();
        n_cmp++; if (instr !== rom_word(16'h0001)) begin n_fail++; $display("FAIL basic_instr2: got %h want %h", instr, rom_word(16'h0001)); end
        n_cmp++; if (instr_addr !== 16'h0001) begin n_fail++; $display("FAIL basic_iaddr2: got %h want 0001", instr_addr); end
        rom_ack = 1'b0;
        tick();
        tick();
        n_cmp++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL basic_stop: got %b want 0", rom_req); end
    endtask

    // PC is 0x0002 on entry.
    task automatic test_slow_rom_and_stall();
        run = 1'b1; instr_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rom_req !== 1'b1 || rom_addr !== 16'h0002 || pc_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL slow_req_hold%0d: req=%b addr=%h inc=%b want 1/0002/0", i, rom_req, rom_addr, pc_inc);
            end
            rom_ack = (i == 4);
            rom_data = (i == 4) ? rom_word(16'h0002) : (rom_word(16'h0002) ^ 16'h5A5A);
            tick();
        end
        rom_ack = 1'b0; rom_data = 16'($urandom);
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (instr_valid !== 1'b1 || instr !== rom_word(16'h0002) || instr_addr !== 16'h0002) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid=%b instr=%h addr=%h want 1/%h/0002", i, instr_valid, instr,
                         instr_addr, rom_word(16'h0002));
            end
            n_cmp++; if (pc_inc !== (i == 0) || rom_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_inc%0d: inc=%b req=%b want %b/0", i, pc_inc, rom_req, (i == 0));
            end
            tick();
        end
        run = 1'b0; instr_ready = 1'b1;
        tick();
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_accept: got %b want 0", instr_valid); end
        tick();
        n_cmp++; if (pc_addr !== 16'h0003 || rom_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_pc: pc=%h req=%b want 0003/0", pc_addr, rom_req);
        end
    endtask

    // PC is 0x0003 on entry.
    task automatic test_flush_req();
        run = 1'b1; instr_ready = 1'b1;
        tick();
        n_cmp++; if (rom_addr !== 16'h0003) begin n_fail++; $display("FAIL freq_raddr: got %h want 0003", rom_addr); end
        flush = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0040;
        tick();
        flush = 1'b0; pc_load = 1'b0;
        n_cmp++; if (rom_req !== 1'b1 || rom_addr !== 16'h0040) begin
            n_fail++; $display("FAIL freq_held: req=%b addr=%h want 1/0040", rom_req, rom_addr);
        end
        tick();
        rom_ack = 1'b1; rom_data = 16'hDEAD;
        tick();
        n_cmp++; if (rom_req !== 1'b1 || rom_addr !== 16'h0040) begin
            n_fail++; $display("FAIL freq_reissue: req=%b addr=%h want 1/0040", rom_req, rom_addr);
        end
        n_cmp++; if (pc_inc !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL freq_drop: inc=%b valid=%b want 0/0", pc_inc, instr_valid);
        end
        rom_data = rom_word(16'h0040);
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== rom_word(16'h0040) || instr_addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL freq_deliver: valid=%b instr=%h addr=%h want 1/%h/0040", instr_valid, instr,
                     instr_addr, rom_word(16'h0040));
        end
        n_cmp++; if (pc_inc !== 1'b1) begin n_fail++; $display("FAIL freq_inc: got %b want 1", pc_inc); end
        rom_ack = 1'b0; run = 1'b0;
        tick();
        tick();
    endtask

    // PC is 0x0041 on entry.
    task automatic test_flush_hold();
        run = 1'b1; instr_ready = 1'b1;
        tick();
        rom_ack = 1'b1; rom_data = rom_word(16'h0041);
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr_addr !== 16'h0041) begin
            n_fail++; $display("FAIL fhold_valid: valid=%b addr=%h want 1/0041", instr_valid, instr_addr);
        end
        rom_ack = 1'b0; flush = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0080;
        tick();
        flush = 1'b0; pc_load = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || rom_req !== 1'b1 || rom_addr !== 16'h0080 || pc_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL fhold_skipwait: valid=%b req=%b addr=%h inc=%b want 0/1/0080/0", instr_valid,
                     rom_req, rom_addr, pc_inc);
        end
        rom_ack = 1'b1; rom_data = rom_word(16'h0080);
        tick();
        n_cmp++; if (instr !== rom_word(16'h0080) || instr_addr !== 16'h0080) begin
            n_fail++; $display("FAIL fhold_next: instr=%h addr=%h want %h/0080", instr, instr_addr, rom_word(16'h0080));
        end
        rom_ack = 1'b0; run = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        run = 1'b1; instr_ready = 1'b0;
        tick();
        rom_ack = 1'b1; rom_data = rom_word(pc_addr);
        tick();
        rom_ack = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || pc_inc !== 1'b0 || instr !== 16'h0 || instr_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL rmid_hold: valid=%b inc=%b instr=%h addr=%h want 0/0/0000/0000", instr_valid, pc_inc,
                     instr, instr_addr);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (rom_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_on: got %b want 1", rom_req); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (rom_req !== 1'b0 || rom_addr !== 16'h0) begin
            n_fail++; $display("FAIL rmid_req_drop: req=%b addr=%h want 0/0000", rom_req, rom_addr);
        end
        run = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rom_ack = 1'($urandom_range(0, 1)); rom_data = 16'($urandom);
            tick();
            n_cmp++; if (rom_req !== 1'b0 || instr_valid !== 1'b0 || pc_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_idle%0d: req=%b valid=%b inc=%b want 0/0/0", i, rom_req, instr_valid, pc_inc);
            end
        end
        rom_ack = 1'b0;
    endtask

    task automatic test_random();
        ent_t        q[$];
        logic        exp_inc;
        logic        pending;
        logic        req_chk;
        logic        req_exp;
        logic [15:0] exp_raddr;
        int          n_deliv;
        exp_inc = 1'b0; pending = 1'b0; req_chk = 1'b0; req_exp = 1'b0; n_deliv = 0;
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            n_cmp++; if (pc_inc !== exp_inc) begin
                n_fail++; $display("FAIL rnd_inc@%0d: got %b want %b", cyc, pc_inc, exp_inc);
            end
            n_cmp++; if (instr_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, instr_valid, (q.size() != 0));
            end
            if (q.size() != 0) begin
                n_cmp++; if (instr !== q[0].d || instr_addr !== q[0].a) begin
                    n_fail++;
                    $display("FAIL rnd_instr@%0d: got %h@%h want %h@%h", cyc, instr, instr_addr, q[0].d, q[0].a);
                end
            end
            exp_raddr = rom_req ? pc_addr : 16'h0;
            n_cmp++; if (rom_addr !== exp_raddr) begin
                n_fail++; $display("FAIL rnd_raddr@%0d: got %h want %h", cyc, rom_addr, exp_raddr);
            end
            if (req_chk) begin
                n_cmp++; if (rom_req !== req_exp) begin
                    n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, rom_req, req_exp);
                end
            end

            run         = ($urandom_range(0, 99) < 85);
            instr_ready = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 99) < 8);
            pc_load     = flush;
            pc_load_val = 16'($urandom);
            rom_ack     = rom_req ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 10);
            rom_data    = (rom_req && rom_ack) ? rom_word(pc_addr) : 16'($urandom);

            // Request-level rules: ack ends a request; any flush seen during it spoils its data.
            exp_inc = 1'b0;
            req_chk = 1'b1;
            if (rom_req) begin
                if (rom_ack) begin
                    if (!pending && !flush) begin
                        q.push_back('{a: pc_addr, d: rom_data});
                        exp_inc = 1'b1;
                        req_exp = 1'b0;
                    end else begin
                        req_exp = run;
                    end
                    pending = 1'b0;
                end else begin
                    if (flush) pending = 1'b1;
                    req_exp = 1'b1;
                end
            end else if (q.size() != 0) begin
                if (flush) begin
                    void'(q.pop_front());
                    req_exp = run;
                end else if (instr_ready) begin
                    void'(q.pop_front());
                    n_deliv++;
                    req_exp = 1'b0;
                end else begin
                    req_exp = 1'b0;
                end
            end else begin
                req_exp = run;
            end
        end
        flush = 1'b0; pc_load = 1'b0; rom_ack = 1'b0;
        n_cmp++; if (n_deliv < 20) begin
            n_fail++; $display("FAIL rnd_progress: delivered %0d want at least 20", n_deliv);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_rom_and_stall();
        test_flush_req();
        test_flush_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
